// File: rtl/decoder_3to8_pipe.sv
// Registered 3-to-8 one-hot decoder with valid/ready handshake and a two-entry skid buffer.
// Optional accepted-code counter on acc_count when DECODER_STATS_EN is defined.
module decoder_3to8_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready
`ifdef DECODER_STATS_EN
  ,
  output logic [15:0] acc_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t     state_reg;
  logic [7:0] m_word_reg;
  logic [7:0] s_word_reg;
  logic       in_ready_reg;
  logic       out_valid_reg;
  logic [7:0] dec_word;
  logic       in_xfer;
  logic       out_xfer;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign dec_word[gi] = (code == 3'(gi));
    end
  endgenerate

  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = out_valid_reg && out_ready;

  // Words are stored already decoded; an invalid slot is kept at zero so y needs no gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      m_word_reg    <= 8'h00;
      s_word_reg    <= 8'h00;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_word_reg    <= dec_word;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            s_word_reg   <= dec_word;
            in_ready_reg <= 1'b0;
            state_reg    <= ST_FULL;
          end else if (in_xfer && out_xfer) begin
            m_word_reg <= dec_word;
          end else if (out_xfer) begin
            m_word_reg    <= 8'h00;
            out_valid_reg <= 1'b0;
            state_reg     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain into M can happen.
          if (out_xfer) begin
            m_word_reg   <= s_word_reg;
            s_word_reg   <= 8'h00;
            in_ready_reg <= 1'b1;
            state_reg    <= ST_ONE;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          m_word_reg    <= 8'h00;
          s_word_reg    <= 8'h00;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign y         = m_word_reg;

`ifdef DECODER_STATS_EN
  logic [15:0] acc_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_count_reg <= 16'h0000;
    end else if (in_xfer && (acc_count_reg != 16'hFFFF)) begin
      acc_count_reg <= acc_count_reg + 16'd1;
    end
  end

  assign acc_count = acc_count_reg;
`endif

endmodule

// File: doc/decoder_3to8_pipe.md
# decoder_3to8_pipe

Registered 3-to-8 line decoder with valid/ready handshaking on both sides. It accepts a 3-bit binary code and emits the matching one-hot 8-bit word. It is the companion to the team's 8-to-3 encoder and sits downstream of it to re-expand encoded line indices. A two-entry skid buffer decouples input and output backpressure so that full throughput is sustained without a combinational ready path.

## Interface
- No parameters. Widths are fixed at 3 in / 8 out.
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- code  input  3  binary line index, meaningful when in_valid=1
- in_valid  input  1  code is presented
- in_ready  output  1  block can accept a code this cycle
- y  output  8  one-hot decoded word; y[k]=1 iff accepted code==k
- out_valid  output  1  y holds a valid word
- out_ready  input  1  downstream consumes y this cycle
- acc_count  output  16  accepted-code counter (present only with DECODER_STATS_EN)

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Decode: y = 8'b1 << code. Exactly one bit is set whenever out_valid=1. y=8'h00 whenever out_valid=0.
- Storage is a main register (M, drives y/out_valid) plus a skid register (S). Occupancy states:
  - EMPTY: M invalid, S invalid. in_ready=1.
  - ONE: M valid, S invalid. in_ready=1.
  - FULL: M valid, S valid. in_ready=0.
- Transitions (in = input transfer, out = output transfer):
  - EMPTY: in → ONE (decoded code loads M).
  - ONE: in && !out → FULL (code loads S). in && out → ONE (code loads M). !in && out → EMPTY. Otherwise hold.
  - FULL: out → ONE (S moves to M, S cleared). Otherwise hold.
- in_ready is driven from a register (= !S.valid). There is no combinational path from out_ready to in_ready.
- Order is preserved strictly FIFO. No code is dropped or duplicated.
- Codes presented while in_ready=0 are ignored. The source must hold them.

## Timing
- Reset values: in_ready=1, out_valid=0, y=8'h00, acc_count=0, state=EMPTY, S cleared.
- Reset takes priority over any simultaneous transfer on the same edge. Reset mid-operation discards both M and S contents.
- Latency is 1 cycle: a code accepted at edge N appears on y/out_valid after edge N.
- Throughput is 1 code per cycle while out_ready=1.
- When out_ready deasserts, at most one further code is accepted (into S). in_ready then drops after that edge.
- in_ready reasserts in the cycle after the edge at which FULL drains to ONE.
- y and out_valid are stable while out_valid=1 && out_ready=0.

## Configuration
- DECODER_STATS_EN defined:
  - adds acc_count, a 16-bit counter incremented on every input transfer.
  - acc_count saturates at 16'hFFFF and does not wrap.
  - acc_count is cleared by rst.
- DECODER_STATS_EN undefined: the acc_count port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then release → in_ready=1, out_valid=0, y=8'h00.
- Streaming: out_ready=1, codes 0..7 on consecutive cycles → y = 01,02,04,…,80 on consecutive cycles, one cycle after each acceptance, no bubbles.
- Backpressure/skid: hold out_ready=0, send 5 then 3 → both accepted, then in_ready=0. y=8'h20 holds stable. Raise out_ready → y=8'h20 then 8'h08. in_ready=1 one cycle after the drain.
- Simultaneous in/out in ONE: M holds 2, in_valid with code 6 while out_ready=1 → next cycle y=8'h40, state ONE, in_ready stays 1.
- Reset mid-operation: FULL with codes 1,4, assert rst with in_valid=1 → next cycle out_valid=0, y=0, in_ready=1, and neither code is emitted.
- Stats (with DECODER_STATS_EN): 70000 accepted codes → acc_count=16'hFFFF. Rejected presentations while in_ready=0 do not increment it.
